// File: rtl/add_err_pkg.sv
// Shared types and default widths for the approximate-adder error monitor.
package add_err_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam int unsigned W_DEF     = 16;
    localparam int unsigned CNT_W_DEF = 32;
    localparam int unsigned ACC_W_DEF = 48;
    localparam int unsigned SQ_W_DEF  = 64;

    // Signed error between two W+1-bit sums needs two bits beyond the operand width
    function automatic int unsigned err_w(input int unsigned w);
        return w + 2;
    endfunction

endpackage

// File: rtl/add_err_calc.sv
// S1/S2 datapath: exact sum and signed error, then |error|, error squared and nonzero flag.
module add_err_calc
    import add_err_pkg::*;
#(
    parameter int unsigned W = W_DEF
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           in_valid,
    input  logic [W-1:0]   in_a,
    input  logic [W-1:0]   in_b,
    input  logic [W:0]     in_sum,
    output logic           out_valid,
    output logic [W+1:0]   abs_err,
    output logic [2*W+3:0] sq_err,
    output logic           nz,
    output logic           pipe_busy_c
);
    localparam int unsigned EW = err_w(W);
    localparam int unsigned QW = 2 * EW;

    logic [W:0]    exact_c;
    logic [EW-1:0] err_c;
    logic [EW-1:0] err_q;
    logic [EW-1:0] abs_c;
    logic          s1_valid;

    assign exact_c = {in_a[W-1], in_a} + {in_b[W-1], in_b};
    assign err_c   = {in_sum[W], in_sum} - {exact_c[W], exact_c};
    assign abs_c   = err_q[EW-1] ? (~err_q + EW'(1)) : err_q;

    assign pipe_busy_c = s1_valid | out_valid;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_valid  <= 1'b0;
            err_q     <= '0;
            out_valid <= 1'b0;
            abs_err   <= '0;
            sq_err    <= '0;
            nz        <= 1'b0;
        end else begin
            s1_valid  <= in_valid;
            err_q     <= err_c;
            out_valid <= s1_valid;
            abs_err   <= abs_c;
            sq_err    <= QW'(abs_c) * QW'(abs_c);
            nz        <= |err_q;
        end
    end

endmodule

// File: rtl/add_err_monitor.sv
// Windowed error statistics for a signed approximate adder: FSM plus saturating accumulators.
module add_err_monitor
    import add_err_pkg::*;
#(
    parameter int unsigned W     = W_DEF,
    parameter int unsigned CNT_W = CNT_W_DEF,
    parameter int unsigned ACC_W = ACC_W_DEF,
    parameter int unsigned SQ_W  = SQ_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [CNT_W-1:0] n_samples,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [W-1:0]     in_a,
    input  logic [W-1:0]     in_b,
    input  logic [W:0]       in_sum,
    output logic             busy,
    output logic             done,
    output logic             sat,
    output logic [CNT_W-1:0] cnt_samples,
    output logic [CNT_W-1:0] cnt_err,
    output logic [ACC_W-1:0] sum_abs_err,
    output logic [W+1:0]     max_abs_err,
    output logic [SQ_W-1:0]  sum_sq_err
);
    localparam int unsigned EW    = err_w(W);
    localparam int unsigned QW    = 2 * EW;
    localparam int unsigned CSW   = CNT_W + 1;
    localparam int unsigned ASW   = ((ACC_W > EW) ? ACC_W : EW) + 1;
    localparam int unsigned SSW   = ((SQ_W > QW) ? SQ_W : QW) + 1;

    state_t           state;
    logic [CNT_W-1:0] target;
    logic [CNT_W-1:0] accepted;

    logic             c_valid;
    logic [EW-1:0]    c_abs;
    logic [QW-1:0]    c_sq;
    logic             c_nz;
    logic             pipe_busy_c;

    add_err_calc #(.W(W)) u_calc (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid & in_ready),
        .in_a        (in_a),
        .in_b        (in_b),
        .in_sum      (in_sum),
        .out_valid   (c_valid),
        .abs_err     (c_abs),
        .sq_err      (c_sq),
        .nz          (c_nz),
        .pipe_busy_c (pipe_busy_c)
    );

    // Widened sums; any bit above the field width means the add would wrap
    logic [CSW-1:0] cnt_s_c;
    logic [CSW-1:0] cnt_e_c;
    logic [ASW-1:0] abs_s_c;
    logic [SSW-1:0] sq_s_c;
    logic           ov_cs_c, ov_ce_c, ov_abs_c, ov_sq_c;

    assign cnt_s_c  = CSW'(cnt_samples) + CSW'(1);
    assign cnt_e_c  = CSW'(cnt_err) + CSW'(c_nz);
    assign abs_s_c  = ASW'(sum_abs_err) + ASW'(c_abs);
    assign sq_s_c   = SSW'(sum_sq_err) + SSW'(c_sq);
    assign ov_cs_c  = cnt_s_c[CNT_W];
    assign ov_ce_c  = cnt_e_c[CNT_W];
    assign ov_abs_c = |abs_s_c[ASW-1:ACC_W];
    assign ov_sq_c  = |sq_s_c[SSW-1:SQ_W];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= IDLE;
            target      <= '0;
            accepted    <= '0;
            in_ready    <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            sat         <= 1'b0;
            cnt_samples <= '0;
            cnt_err     <= '0;
            sum_abs_err <= '0;
            max_abs_err <= '0;
            sum_sq_err  <= '0;
        end else begin
            done <= 1'b0;

            if (c_valid) begin
                cnt_samples <= ov_cs_c  ? '1 : cnt_s_c[CNT_W-1:0];
                cnt_err     <= ov_ce_c  ? '1 : cnt_e_c[CNT_W-1:0];
                sum_abs_err <= ov_abs_c ? '1 : abs_s_c[ACC_W-1:0];
                sum_sq_err  <= ov_sq_c  ? '1 : sq_s_c[SQ_W-1:0];
                if (c_abs > max_abs_err) max_abs_err <= c_abs;
                if (ov_cs_c | ov_ce_c | ov_abs_c | ov_sq_c) sat <= 1'b1;
            end

            case (state)
                IDLE: begin
                    if (start) begin
                        target      <= n_samples;
                        accepted    <= '0;
                        sat         <= 1'b0;
                        cnt_samples <= '0;
                        cnt_err     <= '0;
                        sum_abs_err <= '0;
                        max_abs_err <= '0;
                        sum_sq_err  <= '0;
                        if (n_samples == '0) begin
                            state <= DONE;
                        end else begin
                            state    <= RUN;
                            in_ready <= 1'b1;
                            busy     <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    if (in_valid && in_ready) begin
                        accepted <= accepted + CNT_W'(1);
                        if (accepted + CNT_W'(1) == target) begin
                            in_ready <= 1'b0;
                            state    <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    if (!pipe_busy_c) begin
                        state <= DONE;
                        busy  <= 1'b0;
                    end
                end
                DONE: begin
                    done  <= 1'b1;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_add_err_monitor.sv
// Directed bench for add_err_monitor: default-width instance plus an 8-bit-accumulator instance.
module tb_add_err_monitor;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start, start_s;
    logic [31:0] n_samples;
    logic        in_valid;
    logic [15:0] in_a, in_b;
    logic [16:0] in_sum;

    logic        rdy, busy, done, sat;
    logic [31:0] cnt_s, cnt_e;
    logic [47:0] sabs;
    logic [17:0] mabs;
    logic [63:0] ssq;

    logic        rdy_s, busy_s, done_s, sat_s;
    logic [31:0] cnt_s_s, cnt_e_s;
    logic [7:0]  sabs_s;
    logic [17:0] mabs_s;
    logic [63:0] ssq_s;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    add_err_monitor dut (
        .clk(clk), .rst_n(rst_n), .start(start), .n_samples(n_samples),
        .in_valid(in_valid), .in_ready(rdy), .in_a(in_a), .in_b(in_b), .in_sum(in_sum),
        .busy(busy), .done(done), .sat(sat), .cnt_samples(cnt_s), .cnt_err(cnt_e),
        .sum_abs_err(sabs), .max_abs_err(mabs), .sum_sq_err(ssq)
    );

    add_err_monitor #(.ACC_W(8)) dut_s (
        .clk(clk), .rst_n(rst_n), .start(start_s), .n_samples(n_samples),
        .in_valid(in_valid), .in_ready(rdy_s), .in_a(in_a), .in_b(in_b), .in_sum(in_sum),
        .busy(busy_s), .done(done_s), .sat(sat_s), .cnt_samples(cnt_s_s), .cnt_err(cnt_e_s),
        .sum_abs_err(sabs_s), .max_abs_err(mabs_s), .sum_sq_err(ssq_s)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Offer one sample and hold it until accepted (bounded)
    task automatic send(input logic [15:0] a, input logic [15:0] b, input logic [16:0] s,
                        input bit use_s);
        bit ok = 1'b0;
        in_a = a; in_b = b; in_sum = s; in_valid = 1'b1;
        for (int k = 0; k < 20 && !ok; k++) begin
            ok = use_s ? rdy_s : rdy;
            tick();
        end
        in_valid = 1'b0;
        chk("accept", 64'(ok), 64'd1);
    endtask

    task automatic go(input logic [31:0] n, input bit use_s);
        n_samples = n;
        if (use_s) start_s = 1'b1; else start = 1'b1;
        tick();
        start = 1'b0; start_s = 1'b0;
    endtask

    task automatic wait_done(input bit use_s);
        bit seen = 1'b0;
        for (int k = 0; k < 60 && !seen; k++) begin
            seen = use_s ? done_s : done;
            if (!seen) tick();
        end
        chk("done_seen", 64'(seen), 64'd1);
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; start_s = 1'b0; n_samples = '0;
        in_valid = 1'b0; in_a = '0; in_b = '0; in_sum = '0;
        tick(); tick();
        rst_n = 1'b1;
        tick();
        chk("rst_ready", 64'(rdy), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_cnt", 64'(cnt_s), 64'd0);
        chk("rst_sq", ssq, 64'd0);

        // Exact results; a start during RUN must be ignored
        go(32'd4, 1'b0);
        chk("t1_ready", 64'(rdy), 64'd1);
        chk("t1_busy", 64'(busy), 64'd1);
        n_samples = 32'd99; start = 1'b1; tick(); start = 1'b0;
        send(16'd1, 16'd2, 17'd3, 1'b0);
        send(16'hFFFB, 16'h0007, 17'd2, 1'b0);
        send(16'h7FFF, 16'h7FFF, 17'h0FFFE, 1'b0);
        send(16'h8000, 16'h8000, 17'h10000, 1'b0);
        chk("t1_ready_drop", 64'(rdy), 64'd0);
        wait_done(1'b0);
        chk("t1_cnt", 64'(cnt_s), 64'd4);
        chk("t1_err", 64'(cnt_e), 64'd0);
        chk("t1_abs", 64'(sabs), 64'd0);
        chk("t1_max", 64'(mabs), 64'd0);
        chk("t1_sq", ssq, 64'd0);
        chk("t1_busy_end", 64'(busy), 64'd0);
        tick();
        chk("t1_done_once", 64'(done), 64'd0);

        // Constant +14 offset; first sample checks 3-cycle latency
        go(32'd4, 1'b0);
        send(16'd100, 16'd200, 17'd314, 1'b0);
        chk("t2_lat0", 64'(cnt_s), 64'd0);
        tick();
        chk("t2_lat1", 64'(cnt_s), 64'd0);
        tick();
        chk("t2_lat2", 64'(cnt_s), 64'd1);
        send(16'hFC18, 16'd50, 17'h1FC58, 1'b0);
        send(16'h7FFF, 16'h0001, 17'h0800E, 1'b0);
        send(16'h8000, 16'hFFFF, 17'h1800D, 1'b0);
        wait_done(1'b0);
        chk("t2_cnt", 64'(cnt_s), 64'd4);
        chk("t2_err", 64'(cnt_e), 64'd4);
        chk("t2_abs", 64'(sabs), 64'd56);
        chk("t2_max", 64'(mabs), 64'd14);
        chk("t2_sq", ssq, 64'd784);
        chk("t2_sat", 64'(sat), 64'd0);

        // Errors -3, 0, +5 with gaps; a 4th offered sample must be refused
        go(32'd3, 1'b0);
        send(16'd10, 16'd20, 17'd27, 1'b0);
        tick(); tick();
        send(16'd0, 16'd0, 17'd0, 1'b0);
        tick();
        send(16'hFFFE, 16'hFFFD, 17'd0, 1'b0);
        chk("t3_ready_drop", 64'(rdy), 64'd0);
        in_a = 16'd1; in_b = 16'd1; in_sum = 17'd9; in_valid = 1'b1;
        wait_done(1'b0);
        in_valid = 1'b0;
        chk("t3_cnt", 64'(cnt_s), 64'd3);
        chk("t3_err", 64'(cnt_e), 64'd2);
        chk("t3_abs", 64'(sabs), 64'd8);
        chk("t3_max", 64'(mabs), 64'd5);
        chk("t3_sq", ssq, 64'd34);
        tick();

        // Zero-length window
        go(32'd0, 1'b0);
        chk("t4_done_early", 64'(done), 64'd0);
        chk("t4_ready0", 64'(rdy), 64'd0);
        tick();
        chk("t4_done", 64'(done), 64'd1);
        chk("t4_ready1", 64'(rdy), 64'd0);
        chk("t4_cnt", 64'(cnt_s), 64'd0);
        chk("t4_abs", 64'(sabs), 64'd0);
        chk("t4_max", 64'(mabs), 64'd0);
        tick();
        chk("t4_done_once", 64'(done), 64'd0);

        // Saturation on the 8-bit accumulator instance
        go(32'd20, 1'b1);
        for (int i = 0; i < 20; i++) send(16'd0, 16'd0, 17'd14, 1'b1);
        wait_done(1'b1);
        chk("t5_abs", 64'(sabs_s), 64'd255);
        chk("t5_sat", 64'(sat_s), 64'd1);
        chk("t5_cnt", 64'(cnt_s_s), 64'd20);
        chk("t5_max", 64'(mabs_s), 64'd14);
        chk("t5_sq", ssq_s, 64'd3920);
        chk("t5_main_idle", 64'(cnt_s), 64'd0);
        tick();

        // Reset after 2 of 5 acceptances, then a clean window
        go(32'd5, 1'b0);
        send(16'd1, 16'd1, 17'd7, 1'b0);
        send(16'd1, 16'd1, 17'd7, 1'b0);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk("t6_busy", 64'(busy), 64'd0);
        chk("t6_ready", 64'(rdy), 64'd0);
        chk("t6_cnt", 64'(cnt_s), 64'd0);
        chk("t6_sat_s", 64'(sat_s), 64'd0);
        tick(); tick(); tick();
        chk("t6_no_stale", 64'(cnt_s), 64'd0);
        chk("t6_no_stale_sq", ssq, 64'd0);
        go(32'd2, 1'b0);
        send(16'd1, 16'd1, 17'd3, 1'b0);
        send(16'd2, 16'd2, 17'd2, 1'b0);
        wait_done(1'b0);
        chk("t6_cnt2", 64'(cnt_s), 64'd2);
        chk("t6_err2", 64'(cnt_e), 64'd2);
        chk("t6_abs2", 64'(sabs), 64'd3);
        chk("t6_max2", 64'(mabs), 64'd2);
        chk("t6_sq2", ssq, 64'd5);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
